// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state encodings and counter-width helper for serial_sub
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bits needed to count 0..n-1, never less than one bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_sub_fs.sv
// serial_sub_fs: single-bit full subtractor built from gate primitives so each gate can be pruned individually
module serial_sub_fs (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    wire na, ab_x, d_w, p0, p1, p2, bo_w;

    not g_na (na, a);
    xor g_x0 (ab_x, a, b);
    xor g_x1 (d_w, ab_x, b_in);
    and g_a0 (p0, na, b);
    and g_a1 (p1, na, b_in);
    and g_a2 (p2, b, b_in);
    or  g_o0 (bo_w, p0, p1, p2);

    assign d     = d_w;
    assign b_out = bo_w;

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial LSB-first unsigned subtractor (diff = a - b) with valid/ready on both sides.
// Optional macro SERIAL_SUB_SAT_EN clamps diff to zero when the subtraction borrows.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             borrow;
    logic             d;
    logic             bout;
    logic             last;

    serial_sub_fs u_fs (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .b_in  (borrow),
        .d     (d),
        .b_out (bout)
    );

    // New difference bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
    generate
        if (WIDTH == 1) begin : g_one
            assign res_nxt = d;
        end else begin : g_many
            assign res_nxt = {d, res_sr[WIDTH-1:1]};
        end
    endgenerate

    assign last = (cnt == CW'(WIDTH - 1));

    // Handshake FSM, operand/result shifters, borrow flop and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        borrow   <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    borrow <= bout;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        state      <= ST_DONE;
                        out_valid  <= 1'b1;
                        borrow_out <= bout;
`ifdef SERIAL_SUB_SAT_EN
                        diff       <= bout ? '0 : res_nxt;
`else
                        diff       <= res_nxt;
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: randomized scoreboard bench for serial_sub (honours SERIAL_SUB_SAT_EN if defined)
module tb_serial_sub;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         borrow_out;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   hs_cyc = -100;
    int   outs = 0;
    bit   rand_bp = 1'b0;
    bit   prev_v = 1'b0;

    serial_sub #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_bp) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain unsigned arithmetic, optional clamp to zero on borrow
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.bo = (x < y);
        e.d  = x - y;
`ifdef SERIAL_SUB_SAT_EN
        if (e.bo) e.d = '0;
`endif
        e.acc = 0;
        return e;
    endfunction

    // Monitor: latency on out_valid rise, data compare at each output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_v && q.size() > 0)
                chk("latency", 32'(cyc - q[0].acc), 32'(W));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got diff %0h, expected no output", diff);
                end else begin
                    m_e = q.pop_front();
                    chk("diff", 32'(diff), 32'(m_e.d));
                    chk("borrow_out", 32'(borrow_out), 32'(m_e.bo));
                end
                outs++;
                hs_cyc = cyc;
            end
            prev_v = out_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL accept_timeout: in_ready 0 expected 1");
            return;
        end
        in_valid = 1'b1;
        a = x;
        b = y;
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (push) begin
            exp_t e;
            e = model(x, y);
            e.acc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            $display("FAIL idle_timeout: pending %0d expected 0", q.size());
        end
    endtask

    initial begin
        int n;
        int outs0;
        logic [W-1:0] exp_wrap;
        logic [W-1:0] exp_bp;
`ifdef SERIAL_SUB_SAT_EN
        exp_wrap = '0;
        exp_bp   = '0;
`else
        exp_wrap = 8'hFF;
        exp_bp   = 8'hF0;
`endif
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        do_op(8'h5A, 8'h3C, 1'b1);
        wait_idle();
        chk("basic_diff", 32'(diff), 32'h1E);
        chk("basic_borrow", 32'(borrow_out), 32'd0);

        do_op(8'h00, 8'h01, 1'b1);
        wait_idle();
        chk("wrap_diff", 32'(diff), 32'(exp_wrap));
        chk("wrap_borrow", 32'(borrow_out), 32'd1);

        do_op(8'hFF, 8'hFF, 1'b1);
        @(negedge clk);
        chk("b2b_in_ready_low", 32'(in_ready), 32'd0);
        do_op(8'h80, 8'h7F, 1'b1);
        chk("b2b_accept_gap", 32'((cyc - hs_cyc) >= 2), 32'd1);
        wait_idle();
        chk("b2b_diff", 32'(diff), 32'h01);

        @(posedge clk);
        #1 out_ready = 1'b0;
        do_op(8'h10, 8'h20, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_diff", 32'(diff), 32'(exp_bp));
            chk("bp_borrow", 32'(borrow_out), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);

        do_op(8'h77, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_diff", 32'(diff), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        do_op(8'h03, 8'h02, 1'b1);
        wait_idle();
        chk("post_rst_diff", 32'(diff), 32'h01);

        outs0 = outs;
        do_op(8'h09, 8'h04, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(negedge clk);
        chk("ignore_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        chk("ignore_diff", 32'(diff), 32'h05);
        chk("ignore_out_count", 32'(outs - outs0), 32'd1);

        rand_bp = 1'b1;
        repeat (25) do_op(W'($urandom), W'($urandom), 1'b1);
        wait_idle();
        rand_bp = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
